// File: rtl/conv_sched_pkg.sv
// Shared widths, FSM state encoding, result record and the lane clamp helper
// for the convolution row scheduler.
package conv_sched_pkg;

  localparam int LANE_W    = 12;
  localparam int LANES     = 6;
  localparam int ROW_W     = 128;
  localparam int TAP_W     = 6;
  localparam int RES_W     = LANE_W * LANES;
  localparam int RES_ROW_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [RES_ROW_W-1:0] row;
    logic [RES_W-1:0]     data;
  } res_t;

  // Negative two's-complement lanes are forced to zero.
  function automatic logic [RES_W-1:0] relu_lanes(input logic [RES_W-1:0] d);
    logic [RES_W-1:0] r;
    r = d;
    for (int i = 0; i < LANES; i++) begin
      if (d[i*LANE_W + LANE_W-1]) r[i*LANE_W +: LANE_W] = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_res_fifo.sv
// Result FIFO: flop-based storage whose head entry is read straight from a
// register; exposes occupancy so the scheduler can compute issue credit.
module conv_res_fifo #(
  parameter int W     = 80,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // The scheduler's credit scheme must never offer a write the FIFO cannot take.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && !do_push));

endmodule

// File: rtl/conv_row_sched.sv
// Row scheduler for the 8-pixel x 3-tap convolution array: credit-limited row
// issue, latency tracking and result buffering. Define CONV_SCHED_RELU_EN to clamp negative lanes.
module conv_row_sched
  import conv_sched_pkg::*;
#(
  parameter int NUM_ROWS   = 8,
  parameter int ADDR_W     = 8,
  parameter int PE_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3*TAP_W-1:0]   filter_in,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_req,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [ROW_W-1:0]     rd_data,
  output logic [ROW_W-1:0]     pe_in,
  output logic [3*TAP_W-1:0]   pe_filter,
  input  logic [RES_W-1:0]     pe_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RES_W-1:0]     res_data,
  output logic [ADDR_W-1:0]    res_row
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int IW = $clog2(NUM_ROWS + 1);
  localparam int FW = ADDR_W + RES_W;

  state_t                             state;
  state_t                             state_next;
  logic [IW-1:0]                      issue_cnt;
  logic [CW-1:0]                      in_flight;
  logic [CW-1:0]                      occ;
  logic                               req_d;
  logic [ADDR_W-1:0]                  req_row;
  logic [PE_LATENCY-1:0]              tag_v;
  logic [PE_LATENCY-1:0][ADDR_W-1:0]  tag_row;
  logic                               push;
  logic                               pop;
  logic                               fifo_empty;
  logic                               rows_left;
  logic                               credit_ok;
  logic [RES_W-1:0]                   lanes;
  logic [FW-1:0]                      head;

  assign rows_left = (issue_cnt < IW'(NUM_ROWS));
  // A pop this cycle frees its slot for a row issued this cycle.
  assign credit_ok = (SW'(occ) + SW'(in_flight)) < (SW'(FIFO_DEPTH) + SW'(pop));
  assign push      = tag_v[PE_LATENCY-1];
  assign pop       = res_valid && res_ready;
  assign rd_addr   = ADDR_W'(issue_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (rd_req && issue_cnt == IW'(NUM_ROWS - 1)) state_next = DRAIN;
      DRAIN:   if (in_flight == '0 && (occ == '0 || (occ == CW'(1) && pop))) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == ISSUE) || (state == DRAIN);
    done   = (state == DONE);
    rd_req = (state == ISSUE) && rows_left && credit_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      in_flight <= '0;
      pe_filter <= '0;
      pe_in     <= '0;
      req_d     <= 1'b0;
      req_row   <= '0;
      tag_v     <= '0;
      tag_row   <= '0;
    end else begin
      if (state == IDLE && start) begin
        pe_filter <= filter_in;
        issue_cnt <= '0;
      end else if (rd_req) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      in_flight <= in_flight + CW'(rd_req) - CW'(push);
      req_d     <= rd_req;
      req_row   <= rd_addr;
      if (req_d) pe_in <= rd_data;
      // Tag moves alongside the row through the array pipeline.
      tag_v[0]   <= req_d;
      tag_row[0] <= req_row;
      for (int i = 1; i < PE_LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_row[i] <= tag_row[i-1];
      end
    end
  end

`ifdef CONV_SCHED_RELU_EN
  assign lanes = relu_lanes(pe_out);
`else
  assign lanes = pe_out;
`endif

  conv_res_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({tag_row[PE_LATENCY-1], lanes}),
    .pop       (res_ready),
    .head      (head),
    .empty     (fifo_empty),
    .count     (occ)
  );

  assign res_valid = !fifo_empty;
  assign res_data  = head[RES_W-1:0];
  assign res_row   = head[FW-1 -: ADDR_W];

endmodule
